// File: rtl/chimp_pkg.sv
// Shared types and constants for the chimp memory-game controller.
package chimp_pkg;

    localparam int unsigned NUM_W    = 5;
    localparam int unsigned STRIKE_W = 2;
    localparam int unsigned STATE_W  = 3;

    localparam int unsigned START_LEVEL_DEF = 4;
    localparam int unsigned MAX_LEVEL_DEF   = 31;
    localparam int unsigned MAX_STRIKES_DEF = 3;

    typedef logic [NUM_W-1:0]    num_t;
    typedef logic [STRIKE_W-1:0] strike_t;
    typedef logic [STATE_W-1:0]  state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_CLEAR     = 3'd1;
    localparam state_t S_LOAD      = 3'd2;
    localparam state_t S_SHOW      = 3'd3;
    localparam state_t S_PLAY      = 3'd4;
    localparam state_t S_WIN       = 3'd5;
    localparam state_t S_LOSE      = 3'd6;
    localparam state_t S_GAME_OVER = 3'd7;

    // Increment that sticks at the given ceiling.
    function automatic num_t sat_inc(input num_t v, input num_t ceil);
        return (v >= ceil) ? ceil : num_t'(v + num_t'(1));
    endfunction

endpackage

// File: rtl/chimp_if.sv
// Control/status bundle between the game controller and the board datapath.
interface chimp_if;
    import chimp_pkg::*;

    logic    iStart;
    logic    iDoneLoad;
    logic    iClickValid;
    logic    iClickCorrect;

    logic    oResetBoard;
    logic    oLoadEnable;
    num_t    oNumToLoad;
    logic    oShowEnable;
    num_t    oNumToChoose;
    num_t    oLevel;
    strike_t oStrikes;
    logic    oRoundWin;
    logic    oRoundLose;
    logic    oGameOver;

    modport master (
        output iStart, iDoneLoad, iClickValid, iClickCorrect,
        input  oResetBoard, oLoadEnable, oNumToLoad, oShowEnable, oNumToChoose,
               oLevel, oStrikes, oRoundWin, oRoundLose, oGameOver
    );

    modport slave (
        input  iStart, iDoneLoad, iClickValid, iClickCorrect,
        output oResetBoard, oLoadEnable, oNumToLoad, oShowEnable, oNumToChoose,
               oLevel, oStrikes, oRoundWin, oRoundLose, oGameOver
    );

endinterface

// File: rtl/chimp_pause_timer.sv
// Result-display dwell timer: load starts a PAUSE_CYCLES window, done_c marks its last cycle.
module chimp_pause_timer #(
    parameter int unsigned PAUSE_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done_c
);

    localparam int unsigned CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PAUSE_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             running;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= LOAD_VAL;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign done_c = running && (count == '0);

endmodule

// File: rtl/chimp_ctrl.sv
// Round sequencer for the chimp memory game: clear, place 1..level, play, score, pause.
module chimp_ctrl
    import chimp_pkg::*;
#(
    parameter int unsigned START_LEVEL  = START_LEVEL_DEF,
    parameter int unsigned MAX_LEVEL    = MAX_LEVEL_DEF,
    parameter int unsigned MAX_STRIKES  = MAX_STRIKES_DEF,
    parameter int unsigned PAUSE_CYCLES = 25_000_000
) (
    input logic    clk,
    input logic    iReset,
    chimp_if.slave bus
);

    localparam num_t    LVL_START = num_t'(START_LEVEL);
    localparam num_t    LVL_MAX   = num_t'(MAX_LEVEL);
    localparam strike_t STK_MAX   = strike_t'(MAX_STRIKES);

    state_t  state, state_nxt;
    logic    reset_board, reset_board_nxt;
    logic    load_enable, load_enable_nxt;
    num_t    num_to_load, num_to_load_nxt;
    logic    show_enable, show_enable_nxt;
    num_t    num_to_choose, num_to_choose_nxt;
    num_t    level, level_nxt;
    strike_t strikes, strikes_nxt;
    logic    round_win, round_win_nxt;
    logic    round_lose, round_lose_nxt;
    logic    game_over, game_over_nxt;
    logic    pause_load_c;
    logic    pause_done_c;

    chimp_pause_timer #(
        .PAUSE_CYCLES (PAUSE_CYCLES)
    ) u_pause (
        .clk    (clk),
        .rst    (iReset),
        .load   (pause_load_c),
        .done_c (pause_done_c)
    );

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_nxt         = state;
        reset_board_nxt   = 1'b0;
        load_enable_nxt   = load_enable;
        num_to_load_nxt   = num_to_load;
        show_enable_nxt   = show_enable;
        num_to_choose_nxt = num_to_choose;
        level_nxt         = level;
        strikes_nxt       = strikes;
        round_win_nxt     = 1'b0;
        round_lose_nxt    = 1'b0;
        game_over_nxt     = game_over;
        pause_load_c      = 1'b0;

        case (state)
            S_IDLE, S_GAME_OVER: begin
                if (bus.iStart) begin
                    state_nxt       = S_CLEAR;
                    reset_board_nxt = 1'b1;
                    num_to_load_nxt = num_t'(1);
                    show_enable_nxt = 1'b0;
                    level_nxt       = LVL_START;
                    strikes_nxt     = '0;
                    game_over_nxt   = 1'b0;
                end
            end
            S_CLEAR: begin
                state_nxt       = S_LOAD;
                load_enable_nxt = 1'b1;
            end
            S_LOAD: begin
                if (bus.iDoneLoad) begin
                    if (num_to_load == level) begin
                        state_nxt         = S_SHOW;
                        load_enable_nxt   = 1'b0;
                        show_enable_nxt   = 1'b1;
                        num_to_choose_nxt = num_t'(1);
                    end else begin
                        num_to_load_nxt = num_t'(num_to_load + num_t'(1));
                    end
                end
            end
            S_SHOW, S_PLAY: begin
                if (bus.iClickValid) begin
                    if (!bus.iClickCorrect) begin
                        // Wrong pick: reveal the board for the dwell.
                        state_nxt       = S_LOSE;
                        round_lose_nxt  = 1'b1;
                        strikes_nxt     = strike_t'(strikes + strike_t'(1));
                        show_enable_nxt = 1'b1;
                        pause_load_c    = 1'b1;
                    end else if (num_to_choose == level) begin
                        state_nxt     = S_WIN;
                        round_win_nxt = 1'b1;
                        level_nxt     = sat_inc(level, LVL_MAX);
                        pause_load_c  = 1'b1;
                    end else begin
                        state_nxt         = S_PLAY;
                        num_to_choose_nxt = num_t'(num_to_choose + num_t'(1));
                        show_enable_nxt   = 1'b0;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (pause_done_c) begin
                    if ((state == S_LOSE) && (strikes == STK_MAX)) begin
                        state_nxt     = S_GAME_OVER;
                        game_over_nxt = 1'b1;
                    end else begin
                        state_nxt       = S_CLEAR;
                        reset_board_nxt = 1'b1;
                        num_to_load_nxt = num_t'(1);
                        show_enable_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            state         <= S_IDLE;
            reset_board   <= 1'b1;
            load_enable   <= 1'b0;
            num_to_load   <= '0;
            show_enable   <= 1'b0;
            num_to_choose <= '0;
            level         <= LVL_START;
            strikes       <= '0;
            round_win     <= 1'b0;
            round_lose    <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_nxt;
            reset_board   <= reset_board_nxt;
            load_enable   <= load_enable_nxt;
            num_to_load   <= num_to_load_nxt;
            show_enable   <= show_enable_nxt;
            num_to_choose <= num_to_choose_nxt;
            level         <= level_nxt;
            strikes       <= strikes_nxt;
            round_win     <= round_win_nxt;
            round_lose    <= round_lose_nxt;
            game_over     <= game_over_nxt;
        end
    end

    assign bus.oResetBoard  = reset_board;
    assign bus.oLoadEnable  = load_enable;
    assign bus.oNumToLoad   = num_to_load;
    assign bus.oShowEnable  = show_enable;
    assign bus.oNumToChoose = num_to_choose;
    assign bus.oLevel       = level;
    assign bus.oStrikes     = strikes;
    assign bus.oRoundWin    = round_win;
    assign bus.oRoundLose   = round_lose;
    assign bus.oGameOver    = game_over;

endmodule

// File: tb/tb_chimp_ctrl.sv
// Bench for chimp_ctrl: cycle vector table, directed corner sequences, random rounds vs a game-level model.
module tb_chimp_ctrl;
    import chimp_pkg::*;

    localparam int unsigned PAUSE     = 4;
    localparam int unsigned START_LVL = 4;
    localparam int unsigned MAX_LVL   = 31;
    localparam int unsigned MAX_STK   = 3;
    localparam int unsigned NVEC      = 24;

    typedef struct packed {
        logic rst, st, dl, cv, cc;
    } ins_t;

    typedef struct packed {
        logic       rb, le;
        logic [4:0] ntl;
        logic       sh;
        logic [4:0] ntc;
        logic [4:0] lvl;
        logic [1:0] stk;
        logic       w, l, go;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t o;
    } vec_t;

    localparam outs_t RST_O  = {1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'(START_LVL), 2'd0, 3'b000};
    localparam outs_t IDLE_O = {1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'(START_LVL), 2'd0, 3'b000};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    int   exp_level;
    int   exp_strikes;
    vec_t tbl [NVEC];

    chimp_if bus ();

    chimp_ctrl #(
        .START_LEVEL  (START_LVL),
        .MAX_LEVEL    (MAX_LVL),
        .MAX_STRIKES  (MAX_STK),
        .PAUSE_CYCLES (PAUSE)
    ) dut (
        .clk    (clk),
        .iReset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input logic v, input logic c);
        rst               = r;
        bus.iStart        = s;
        bus.iDoneLoad     = d;
        bus.iClickValid   = v;
        bus.iClickCorrect = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t cur();
        outs_t o;
        o.rb  = bus.oResetBoard;
        o.le  = bus.oLoadEnable;
        o.ntl = bus.oNumToLoad;
        o.sh  = bus.oShowEnable;
        o.ntc = bus.oNumToChoose;
        o.lvl = bus.oLevel;
        o.stk = bus.oStrikes;
        o.w   = bus.oRoundWin;
        o.l   = bus.oRoundLose;
        o.go  = bus.oGameOver;
        return o;
    endfunction

    function automatic logic rbit(input bit en);
        return en ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // Called right after the cycle that entered CLEAR.
    task automatic enter_load();
        drive(0, 0, 0, 0, 0);
        tick();
        check("load_entry", 32'({bus.oResetBoard, bus.oLoadEnable, bus.oNumToLoad}),
              32'({1'b0, 1'b1, 5'd1}));
    endtask

    task automatic load_board(input bit rnd);
        int lv;
        lv = exp_level;
        for (int k = 1; k <= lv; k++) begin
            int gaps;
            gaps = rnd ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                drive(0, rbit(1), 0, rbit(1), rbit(1));
                tick();
                check("load_hold", 32'({bus.oLoadEnable, bus.oNumToLoad}), 32'({1'b1, 5'(k)}));
            end
            drive(0, 0, 1, 0, 0);
            tick();
            if (k < lv)
                check("load_next", 32'({bus.oLoadEnable, bus.oNumToLoad}), 32'({1'b1, 5'(k + 1)}));
            else
                check("show_entry", 32'({bus.oLoadEnable, bus.oShowEnable, bus.oNumToChoose}),
                      32'({1'b0, 1'b1, 5'd1}));
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic click_round(input bit win, input bit rnd);
        int lv;
        int wrong_at;
        lv       = exp_level;
        wrong_at = win ? 0 : int'($urandom_range(1, lv));
        for (int k = 1; k <= lv; k++) begin
            int gaps;
            gaps = rnd ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                drive(0, rbit(1), rbit(1), 0, rbit(1));
                tick();
                check("choose_hold", 32'({bus.oShowEnable, bus.oNumToChoose}),
                      32'({(k == 1) ? 1'b1 : 1'b0, 5'(k)}));
            end
            if (k == wrong_at) begin
                drive(0, 0, 0, 1, 0);
                tick();
                exp_strikes++;
                check("lose_pulse", 32'({bus.oRoundLose, bus.oRoundWin, bus.oShowEnable, bus.oStrikes}),
                      32'({1'b1, 1'b0, 1'b1, 2'(exp_strikes)}));
                break;
            end
            drive(0, 0, 0, 1, 1);
            tick();
            if (k < lv) begin
                check("choose_next", 32'({bus.oShowEnable, bus.oNumToChoose, bus.oRoundWin}),
                      32'({1'b0, 5'(k + 1), 1'b0}));
            end else begin
                exp_level = (exp_level >= int'(MAX_LVL)) ? int'(MAX_LVL) : exp_level + 1;
                check("win_pulse", 32'({bus.oRoundWin, bus.oRoundLose, bus.oLevel}),
                      32'({1'b1, 1'b0, 5'(exp_level)}));
            end
        end
        drive(0, 0, 0, 0, 0);
    endtask

    // Pulse cycle already seen; the remaining dwell must stay quiet, then leave on time.
    task automatic pause_phase(input bit rnd);
        for (int p = 1; p < int'(PAUSE); p++) begin
            drive(0, rbit(rnd), rbit(rnd), rbit(rnd), rbit(rnd));
            tick();
            check("pause_quiet", 32'({bus.oResetBoard, bus.oRoundWin, bus.oRoundLose, bus.oLevel,
                                      bus.oStrikes, bus.oGameOver}),
                  32'({3'b000, 5'(exp_level), 2'(exp_strikes), 1'b0}));
        end
        drive(0, 0, 0, 0, 0);
        tick();
        if (exp_strikes == int'(MAX_STK))
            check("game_over", 32'({bus.oGameOver, bus.oResetBoard, bus.oLevel, bus.oStrikes}),
                  32'({1'b1, 1'b0, 5'(exp_level), 2'(exp_strikes)}));
        else
            check("clear_entry", 32'({bus.oResetBoard, bus.oNumToLoad, bus.oGameOver}),
                  32'({1'b1, 5'd1, 1'b0}));
    endtask

    task automatic restart();
        for (int p = 0; p < 3; p++) begin
            drive(0, 0, 1, 1, rbit(1));
            tick();
            check("go_hold", 32'({bus.oGameOver, bus.oResetBoard, bus.oLevel, bus.oStrikes}),
                  32'({1'b1, 1'b0, 5'(exp_level), 2'(exp_strikes)}));
        end
        drive(0, 1, 0, 0, 0);
        tick();
        exp_level   = START_LVL;
        exp_strikes = 0;
        check("restart", 32'({bus.oResetBoard, bus.oGameOver, bus.oLevel, bus.oStrikes, bus.oNumToLoad}),
              32'({1'b1, 1'b0, 5'(START_LVL), 2'd0, 5'd1}));
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic play_round(input bit win, input bit rnd);
        enter_load();
        load_board(rnd);
        click_round(win, rnd);
        pause_phase(rnd);
        if (exp_strikes == int'(MAX_STK)) restart();
    endtask

    initial begin
        // ins: rst st dl cv cc | rb le ntl sh ntc lvl stk w l go
        tbl[0]  = {5'b10000, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[1]  = {5'b00000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[2]  = {5'b01000, 1'b1, 1'b0, 5'd1, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[3]  = {5'b00000, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[4]  = {5'b00010, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[5]  = {5'b00100, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[6]  = {5'b01000, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[7]  = {5'b00100, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[8]  = {5'b00011, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[9]  = {5'b00100, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[10] = {5'b00000, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 5'd4, 2'd0, 3'b000};
        tbl[11] = {5'b00100, 1'b0, 1'b0, 5'd4, 1'b1, 5'd1, 5'd4, 2'd0, 3'b000};
        tbl[12] = {5'b00100, 1'b0, 1'b0, 5'd4, 1'b1, 5'd1, 5'd4, 2'd0, 3'b000};
        tbl[13] = {5'b00001, 1'b0, 1'b0, 5'd4, 1'b1, 5'd1, 5'd4, 2'd0, 3'b000};
        tbl[14] = {5'b00011, 1'b0, 1'b0, 5'd4, 1'b0, 5'd2, 5'd4, 2'd0, 3'b000};
        tbl[15] = {5'b00011, 1'b0, 1'b0, 5'd4, 1'b0, 5'd3, 5'd4, 2'd0, 3'b000};
        tbl[16] = {5'b01000, 1'b0, 1'b0, 5'd4, 1'b0, 5'd3, 5'd4, 2'd0, 3'b000};
        tbl[17] = {5'b00011, 1'b0, 1'b0, 5'd4, 1'b0, 5'd4, 5'd4, 2'd0, 3'b000};
        tbl[18] = {5'b00011, 1'b0, 1'b0, 5'd4, 1'b0, 5'd4, 5'd5, 2'd0, 3'b100};
        tbl[19] = {5'b00010, 1'b0, 1'b0, 5'd4, 1'b0, 5'd4, 5'd5, 2'd0, 3'b000};
        tbl[20] = {5'b01100, 1'b0, 1'b0, 5'd4, 1'b0, 5'd4, 5'd5, 2'd0, 3'b000};
        tbl[21] = {5'b00011, 1'b0, 1'b0, 5'd4, 1'b0, 5'd4, 5'd5, 2'd0, 3'b000};
        tbl[22] = {5'b00000, 1'b1, 1'b0, 5'd1, 1'b0, 5'd4, 5'd5, 2'd0, 3'b000};
        tbl[23] = {5'b00000, 1'b0, 1'b1, 5'd1, 1'b0, 5'd4, 5'd5, 2'd0, 3'b000};

        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i].i.rst, tbl[i].i.st, tbl[i].i.dl, tbl[i].i.cv, tbl[i].i.cc);
            tick();
            check($sformatf("vec%0d", i), 32'(cur()), 32'(tbl[i].o));
        end

        // Three lost rounds in a row end the game; iStart restarts at the start level.
        exp_level   = 5;
        exp_strikes = 0;
        load_board(0);
        click_round(0, 0);
        pause_phase(0);
        play_round(0, 0);
        play_round(0, 0);

        // Reset racing a winning click in PLAY.
        enter_load();
        load_board(0);
        for (int k = 1; k < exp_level; k++) begin
            drive(0, 0, 0, 1, 1);
            tick();
        end
        drive(1, 0, 0, 1, 1);
        tick();
        check("rst_vs_win", 32'(cur()), 32'(RST_O));
        drive(0, 0, 0, 0, 0);
        tick();
        check("idle_after_rst_win", 32'(cur()), 32'(IDLE_O));

        // Reset racing a losing click in PLAY.
        drive(0, 1, 0, 0, 0);
        tick();
        check("clear_after_idle", 32'({bus.oResetBoard, bus.oNumToLoad}), 32'({1'b1, 5'd1}));
        enter_load();
        load_board(0);
        drive(0, 0, 0, 1, 1);
        tick();
        drive(1, 0, 0, 1, 0);
        tick();
        check("rst_vs_lose", 32'(cur()), 32'(RST_O));
        drive(0, 0, 0, 0, 0);
        tick();
        check("idle_after_rst_lose", 32'(cur()), 32'(IDLE_O));
        tick();
        check("idle_quiet", 32'(cur()), 32'(IDLE_O));
        drive(0, 1, 0, 0, 0);
        tick();
        check("clear_after_idle2", 32'({bus.oResetBoard, bus.oNumToLoad}), 32'({1'b1, 5'd1}));

        // Win up to the ceiling, then once more.
        while (exp_level < int'(MAX_LVL)) play_round(1, 0);
        play_round(1, 0);
        check("level_sat", 32'(bus.oLevel), 32'(MAX_LVL));

        // Random rounds with stray inputs, against the game-level model.
        drive(1, 0, 0, 0, 0);
        tick();
        check("rst_random", 32'(cur()), 32'(RST_O));
        drive(0, 1, 0, 0, 0);
        tick();
        exp_level   = START_LVL;
        exp_strikes = 0;
        check("clear_random", 32'({bus.oResetBoard, bus.oLevel}), 32'({1'b1, 5'(START_LVL)}));
        for (int r = 0; r < 25; r++) play_round(($urandom_range(0, 2) != 0), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/chimp_ctrl.md
CHIMP_CTRL -- requirements
Module: chimp_ctrl

Interface
REQ-001 Parameter START_LEVEL, 4, count of numbers placed in the first round.
REQ-002 Parameter MAX_LEVEL, 31, level saturation value; must fit the 5-bit number field and the 64-cell board.
REQ-003 Parameter MAX_STRIKES, 3, number of failed rounds that ends the game.
REQ-004 Parameter PAUSE_CYCLES, 25_000_000, result-display dwell in clk cycles; must be at least 1.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 iReset  in  1  synchronous, active-high reset.
REQ-007 iStart  in  1  level; starts a game from IDLE or GAME_OVER.
REQ-008 iDoneLoad  in  1  datapath pulse: current oNumToLoad written to a free cell.
REQ-009 iClickValid  in  1  one-cycle pulse: player clicked an occupied cell.
REQ-010 iClickCorrect  in  1  qualified by iClickValid; 1 = clicked cell holds oNumToChoose.
REQ-011 oResetBoard  out  1  clear all board cells.
REQ-012 oLoadEnable  out  1  request placement of oNumToLoad.
REQ-013 oNumToLoad  out  5  number being placed (1..level).
REQ-014 oShowEnable  out  1  numbers visible when 1.
REQ-015 oNumToChoose  out  5  next number the player must click.
REQ-016 oLevel  out  5  current level.
REQ-017 oStrikes  out  2  failed rounds this game.
REQ-018 oRoundWin / oRoundLose  out  1 each  one-cycle pulses on round result.
REQ-019 oGameOver  out  1  high while in GAME_OVER.

Function
REQ-020 FSM states: IDLE, CLEAR, LOAD, SHOW, PLAY, WIN, LOSE, GAME_OVER; all outputs registered.
REQ-021 IDLE: iStart -> CLEAR; oLevel=START_LEVEL, oStrikes=0.
REQ-022 CLEAR: oResetBoard=1 for exactly one cycle; oNumToLoad=1; next state LOAD.
REQ-023 LOAD: oLoadEnable=1 and oNumToLoad held stable until iDoneLoad.
REQ-024 On iDoneLoad in LOAD: if oNumToLoad==oLevel -> SHOW with oLoadEnable=0 next cycle; else oNumToLoad+1.
REQ-025 iDoneLoad outside LOAD is ignored.
REQ-026 Entering SHOW: oShowEnable=1, oNumToChoose=1.
REQ-027 SHOW/PLAY, iClickValid&iClickCorrect: if oNumToChoose==oLevel -> WIN; else oNumToChoose+1, state PLAY, oShowEnable=0 from next cycle.
REQ-028 SHOW/PLAY, iClickValid&!iClickCorrect -> LOSE; oShowEnable=1 (reveal board).
REQ-029 iClickValid outside SHOW/PLAY is ignored; iClickCorrect ignored when iClickValid=0.
REQ-030 WIN entry: oRoundWin pulses one cycle; oLevel+1, saturating at MAX_LEVEL.
REQ-031 LOSE entry: oRoundLose pulses one cycle; oStrikes+1.
REQ-032 WIN/LOSE dwell exactly PAUSE_CYCLES cycles, then LOSE with oStrikes==MAX_STRIKES -> GAME_OVER, otherwise -> CLEAR.
REQ-033 GAME_OVER: oGameOver=1, board untouched, oLevel/oStrikes held; iStart -> CLEAR with oLevel=START_LEVEL, oStrikes=0.
REQ-034 iStart in any state other than IDLE/GAME_OVER is ignored.

Reset
REQ-035 iReset has priority over every other input and forces IDLE in the next cycle.
REQ-036 Reset values: oResetBoard=1 (board cleared during reset), all other outputs 0, oLevel=START_LEVEL, pause counter 0.
REQ-037 Reset mid-LOAD, SHOW, PLAY or pause abandons the round; no result pulse is emitted.

Structure
REQ-038 Package chimp_pkg holds the state enum, the 5-bit number type and the default START_LEVEL/MAX_LEVEL/MAX_STRIKES constants.
REQ-039 Sub-module chimp_pause_timer: load/count-down to zero with a done pulse, width derived from PAUSE_CYCLES.

Verification (PAUSE_CYCLES=4)
REQ-040 Reset then iStart, iDoneLoad after 2 cycles each -> one oResetBoard pulse, oNumToLoad 1,2,3,4, SHOW entered with oShowEnable=1.
REQ-041 Correct clicks 1..4 -> oShowEnable=0 after first click, oRoundWin pulse, 4 pause cycles, CLEAR, oLevel=5.
REQ-042 Wrong click three rounds running -> oStrikes 1,2,3, GAME_OVER, oGameOver=1; iStart -> oLevel=4, oStrikes=0.
REQ-043 oLevel=31 and round won -> oLevel stays 31.
REQ-044 iReset asserted in PLAY with iClickValid in the same cycle -> IDLE, no oRoundWin/oRoundLose pulse.
REQ-045 iClickValid during LOAD/pause and iDoneLoad during SHOW -> no state, counter or output change.
